sound_cmd_fifo: RTL and testbench



---
 rtl/sound_cmd_fifo.sv | 135 +++++++++++++
 tb/tb_sound_cmd_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_cmd_fifo.sv
// Sound command FIFO feeding RIOT port A: queues CPU command bytes and presents them one at a time with a PA7 low strobe.
// Optional hold timeout enabled by defining SOUND_CMD_FIFO_TIMEOUT_EN.
module sound_cmd_fifo #(
    parameter int DEPTH_LOG2     = 2,
    parameter int STROBE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  wr_i,
    input  logic [6:0]            wr_data_i,
    input  logic                  ack_i,
    output logic [7:0]            pa_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o,
    output logic                  busy_o,
    output logic                  overflow_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [7:0] STB_LOAD = 8'(STROBE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STROBE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 255 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("sound_cmd_fifo: STROBE_CYCLES or TIMEOUT_CYCLES out of range");
    end

    logic [6:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [1:0]            state_q, state_d;
    logic [7:0]            stb_q, stb_d;
    logic [6:0]            cmd_q, cmd_d;
    logic                  strobe_n_q, strobe_n_d;
    logic                  ovf_q, ovf_d;
    logic                  full, pop, push, hold_exit;

    assign full = (count_q == DEPTH_CNT);
    assign pop  = (state_q == ST_IDLE) && (count_q != '0);
    // A pop in the same cycle frees a slot, so a write on a full FIFO still lands.
    assign push = wr_i && (!full || pop);

`ifdef SOUND_CMD_FIFO_TIMEOUT_EN
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_q, tmo_d;

    assign hold_exit = ack_i || (tmo_q == '0);

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ST_STROBE && stb_q == '0)
            tmo_d = TMO_LOAD;
        else if (state_q == ST_HOLD && tmo_q != '0)
            tmo_d = tmo_q - 16'd1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    assign hold_exit = ack_i;
`endif

    always_comb begin
        state_d    = state_q;
        stb_d      = stb_q;
        cmd_d      = cmd_q;
        strobe_n_d = strobe_n_q;
        case (state_q)
            ST_IDLE: if (pop) begin
                cmd_d      = mem_q[rd_ptr_q];
                strobe_n_d = 1'b0;
                stb_d      = STB_LOAD;
                state_d    = ST_STROBE;
            end
            ST_STROBE: if (stb_q == '0) begin
                strobe_n_d = 1'b1;
                state_d    = ST_HOLD;
            end else begin
                stb_d = stb_q - 8'd1;
            end
            ST_HOLD: if (hold_exit) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q || (wr_i && full && !pop);
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            stb_q      <= '0;
            cmd_q      <= '0;
            strobe_n_q <= 1'b1;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stb_q      <= stb_d;
            cmd_q      <= cmd_d;
            strobe_n_q <= strobe_n_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    assign pa_o       = {strobe_n_q, cmd_q};
    assign count_o    = count_q;
    assign full_o     = full;
    assign busy_o     = (state_q != ST_IDLE);
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_sound_cmd_fifo.sv
// Scoreboard bench for sound_cmd_fifo: stimulus queues expected commands, a PA7 monitor checks order and strobe width.
module tb_sound_cmd_fifo;
    localparam int DL2 = 2;
    localparam int STB = 8;
    localparam int TMO = 16;

    logic         clk_sys = 1'b0;
    logic         reset = 1'b1;
    logic         wr_i = 1'b0;
    logic [6:0]   wr_data_i = '0;
    logic         ack_i = 1'b0;
    logic [7:0]   pa_o;
    logic [DL2:0] count_o;
    logic         full_o, busy_o, overflow_o;

    sound_cmd_fifo #(.DEPTH_LOG2(DL2), .STROBE_CYCLES(STB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_sys(clk_sys), .reset(reset), .wr_i(wr_i), .wr_data_i(wr_data_i), .ack_i(ack_i),
        .pa_o(pa_o), .count_o(count_o), .full_o(full_o), .busy_o(busy_o), .overflow_o(overflow_o)
    );

    always #5 clk_sys = ~clk_sys;

    int vecs = 0;
    int errs = 0;
    logic [6:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic write(input logic [6:0] d, input bit accept);
        wr_i = 1'b1;
        wr_data_i = d;
        if (accept) exp_q.push_back(d);
        tick();
        wr_i = 1'b0;
    endtask

    task automatic ack();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
    endtask

    task automatic wait_hold(input string nm);
        int n = 0;
        while (!(busy_o && pa_o[7]) && n < 200) begin
            tick();
            n++;
        end
        vecs++;
        if (n >= 200) begin
            errs++;
            $display("FAIL %s: HOLD not reached within 200 cycles", nm);
        end
    endtask

    // Monitor: each falling PA7 must present the next expected code; each low pulse must last STB cycles.
    logic prev7 = 1'b1;
    bit   in_low = 1'b0;
    int   low_len = 0;
    always @(negedge clk_sys) begin
        logic [6:0] e;
        if (reset) begin
            in_low = 1'b0;
            prev7  = 1'b1;
        end else begin
            if (prev7 && !pa_o[7]) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_strobe: got code %0h expected no strobe", pa_o[6:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (pa_o[6:0] !== e) begin
                        errs++;
                        $display("FAIL cmd_order: got %0h expected %0h", pa_o[6:0], e);
                    end
                end
                in_low  = 1'b1;
                low_len = 1;
            end else if (in_low && !pa_o[7]) begin
                low_len++;
            end else if (in_low && pa_o[7]) begin
                in_low = 1'b0;
                vecs++;
                if (low_len != STB) begin
                    errs++;
                    $display("FAIL strobe_width: got %0d expected %0d", low_len, STB);
                end
            end
            prev7 = pa_o[7];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int maxc;
        // reset state
        tick(); tick();
        reset = 1'b0;
        chk("rst_pa", pa_o, 8'h80);
        chk("rst_count", count_o, 0);
        chk("rst_full", full_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovf", overflow_o, 0);

        // single command, 2-cycle latency
        write(7'h2A, 1);
        chk("lat_count1", count_o, 1);
        chk("lat_pa_idle", pa_o, 8'h80);
        tick();
        chk("lat_pa_strobe", pa_o, 8'h2A);
        chk("lat_count0", count_o, 0);
        chk("lat_busy", busy_o, 1);
        wait_hold("single");
        chk("hold_pa", pa_o, 8'hAA);
        repeat (3) tick();
        chk("hold_busy", busy_o, 1);
        ack();
        chk("ack_idle", busy_o, 0);
        chk("idle_keep_pa", pa_o, 8'hAA);

        // back-to-back queueing
        maxc = 0;
        write(7'h01, 1); if (int'(count_o) > maxc) maxc = int'(count_o);
        write(7'h02, 1); if (int'(count_o) > maxc) maxc = int'(count_o);
        write(7'h03, 1); if (int'(count_o) > maxc) maxc = int'(count_o);
        chk("queue_peak", maxc, 2);
        for (int k = 0; k < 3; k++) begin
            wait_hold("queue");
            ack();
            chk("gap_pa7_high", pa_o[7], 1);
            chk("gap_idle", busy_o, 0);
            tick();
            chk("restart_pa7", pa_o[7], (k < 2) ? 0 : 1);
        end

        // overflow: fifth write while full in HOLD is dropped
        write(7'h20, 1);
        wait_hold("ovf");
        write(7'h21, 1);
        write(7'h22, 1);
        write(7'h23, 1);
        write(7'h24, 1);
        write(7'h25, 0);
        chk("ovf_count", count_o, 4);
        chk("ovf_full", full_o, 1);
        chk("ovf_flag", overflow_o, 1);
        ack();
        for (int k = 0; k < 4; k++) begin
            wait_hold("drain");
            ack();
        end
        repeat (20) tick();
        chk("drain_count", count_o, 0);
        chk("drain_busy", busy_o, 0);
        chk("ovf_sticky", overflow_o, 1);
        chk("drain_all_seen", exp_q.size(), 0);

        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_clears_ovf", overflow_o, 0);

        // full boundary: write on the pop cycle while full
        write(7'h30, 1);
        wait_hold("full");
        write(7'h31, 1);
        write(7'h32, 1);
        write(7'h33, 1);
        write(7'h34, 1);
        chk("full_count", count_o, 4);
        chk("full_ovf0", overflow_o, 0);
        ack();
        chk("full_idle_full", full_o, 1);
        chk("full_idle_busy", busy_o, 0);
        write(7'h35, 1);
        chk("popwr_count", count_o, 4);
        chk("popwr_full", full_o, 1);
        chk("popwr_ovf", overflow_o, 0);
        chk("popwr_pa", pa_o, 8'h31);

        // ack during STROBE is ignored
        tick(); tick();
        ack();
        chk("ign_ack_strobe", pa_o[7], 0);
        wait_hold("ign_ack");
        repeat (5) tick();
        chk("ign_ack_busy", busy_o, 1);
        chk("ign_ack_pa", pa_o, 8'hB1);

        // reset during STROBE with 3 queued
        ack();
        tick();
        chk("mid_count3", count_o, 3);
        chk("mid_strobe", pa_o, 8'h32);
        reset = 1'b1;
        exp_q.delete();
        tick();
        chk("mid_rst_pa", pa_o, 8'h80);
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        tick();
        reset = 1'b0;
        repeat (30) tick();
        chk("mid_rst_quiet", pa_o, 8'h80);

        // HOLD persistence / timeout
        write(7'h40, 1);
        wait_hold("tmo");
`ifdef SOUND_CMD_FIFO_TIMEOUT_EN
        repeat (TMO - 1) tick();
        chk("tmo_before", busy_o, 1);
        tick();
        chk("tmo_expired", busy_o, 0);
        chk("tmo_pa", pa_o, 8'hC0);
`else
        repeat (10000) tick();
        chk("no_tmo_busy", busy_o, 1);
        chk("no_tmo_pa", pa_o, 8'hC0);
        ack();
        chk("no_tmo_ack", busy_o, 0);
`endif
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
